// File: rtl/tnn_tree_walker.sv
// Sequential decision-tree walker: one node per cycle through an external comparator.
// Optional TNN_WALK_PATHLEN_EN adds a path_len output counting comparator uses per vector.
module tnn_tree_walker #(
  parameter int unsigned N_FEAT  = 11,
  parameter int unsigned FEAT_W  = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CLASS_W = 3,
  localparam int unsigned FIDX_W = $clog2(N_FEAT),
  localparam int unsigned NODES  = (1 << (DEPTH + 1)) - 1,
  localparam int unsigned AW     = $clog2(NODES),
  localparam int unsigned NW     = 1 + FIDX_W + FEAT_W + CLASS_W,
  localparam int unsigned PL_W   = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic [FEAT_W-1:0]        cmp_a,
  output logic [FEAT_W-1:0]        cmp_b,
  input  logic                     cmp_gt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [NW-1:0]            cfg_data,
  output logic                     cfg_busy
`ifdef TNN_WALK_PATHLEN_EN
  ,
  output logic [PL_W-1:0]          path_len
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WALK = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned LEAF_BASE = (1 << DEPTH) - 1;
  // Out-of-range feature index in the reset word keeps cmp_a at 0 on an unconfigured tree.
  localparam logic [NW-1:0] RST_WORD = {1'b1, {FIDX_W{1'b1}}, {FEAT_W{1'b0}}, {CLASS_W{1'b0}}};

  logic [1:0]                state_q, state_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic [N_FEAT*FEAT_W-1:0]  feat_q;
  logic [CLASS_W-1:0]        class_q;
  logic [NW-1:0]             node_q [NODES];

  logic [NW-1:0]      node;
  logic               node_is_leaf;
  logic               node_leaf;
  logic [FIDX_W-1:0]  node_fidx;
  logic [FEAT_W-1:0]  node_thr;
  logic [CLASS_W-1:0] node_cls;
  logic [FEAT_W-1:0]  sel_feat;
  logic               accept;

  assign node = node_q[idx_q];
  assign {node_is_leaf, node_fidx, node_thr, node_cls} = node;
  assign node_leaf = node_is_leaf | (idx_q >= AW'(LEAF_BASE));
  assign accept    = (state_q == IDLE) & in_valid;

  always_comb begin
    sel_feat = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (node_fidx == FIDX_W'(k)) sel_feat = feat_q[k*FEAT_W +: FEAT_W];
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign cfg_busy  = (state_q != IDLE);
  assign out_class = class_q;
  assign cmp_a     = (state_q == WALK) ? sel_feat : '0;
  assign cmp_b     = (state_q == WALK) ? node_thr : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = WALK;
          idx_d   = '0;
        end
      end
      WALK: begin
        if (node_leaf) begin
          state_d = DONE;
        end else begin
          idx_d = {idx_q[AW-2:0], 1'b0} + AW'(1) + AW'(cmp_gt);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      feat_q  <= '0;
      class_q <= '0;
      for (int i = 0; i < NODES; i++) node_q[i] <= RST_WORD;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) feat_q <= in_feat;
      if ((state_q == WALK) && node_leaf) class_q <= node_cls;
      if (cfg_we && (state_q == IDLE) && (cfg_addr < AW'(NODES))) node_q[cfg_addr] <= cfg_data;
    end
  end

`ifdef TNN_WALK_PATHLEN_EN
  logic [PL_W-1:0] path_len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      path_len_q <= '0;
    end else if (accept) begin
      path_len_q <= '0;
    end else if ((state_q == WALK) && !node_leaf) begin
      path_len_q <= path_len_q + PL_W'(1);
    end
  end

  assign path_len = path_len_q;
`endif

endmodule

// File: tb/tb_tnn_tree_walker.sv
// Randomised self-checking bench for tnn_tree_walker against a node-table walk model.
module tb_tnn_tree_walker;

  localparam int NF    = 11;
  localparam int FW    = 3;
  localparam int NODES = 31;
  localparam int LB    = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [NF*FW-1:0] in_feat;
  logic [2:0]    cmp_a, cmp_b;
  logic          cmp_gt;
  logic          out_valid, out_ready;
  logic [2:0]    out_class;
  logic          cfg_we;
  logic [4:0]    cfg_addr;
  logic [10:0]   cfg_data;
  logic          cfg_busy;
`ifdef TNN_WALK_PATHLEN_EN
  logic [2:0]    path_len;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  bit m_leaf [NODES];
  int m_fidx [NODES];
  int m_thr  [NODES];
  int m_cls  [NODES];
  int feat   [NF];
  int exp_a[$];
  int exp_b[$];
  int exp_cls;
  int exp_pl;

  // Exact comparator stands in for the approximate one.
  assign cmp_gt = (cmp_a > cmp_b);

  always #5 clk = ~clk;

  tnn_tree_walker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_gt    (cmp_gt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy)
`ifdef TNN_WALK_PATHLEN_EN
    ,
    .path_len  (path_len)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NODES; i++) begin
      m_leaf[i] = 1'b1;
      m_fidx[i] = 15;
      m_thr[i]  = 0;
      m_cls[i]  = 0;
    end
  endfunction

  // Walk the model tree for the current feat[], recording the operand pair seen each step.
  function automatic void model_walk();
    int idx;
    int a;
    idx = 0;
    exp_pl = 0;
    exp_a.delete();
    exp_b.delete();
    while (1) begin
      a = (m_fidx[idx] < NF) ? feat[m_fidx[idx]] : 0;
      exp_a.push_back(a);
      exp_b.push_back(m_thr[idx]);
      if (m_leaf[idx] || idx >= LB) begin
        exp_cls = m_cls[idx];
        break;
      end
      exp_pl++;
      idx = 2 * idx + 1 + ((a > m_thr[idx]) ? 1 : 0);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_eq("rst_in_ready",  32'(in_ready),  1);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_class", 32'(out_class), 0);
    check_eq("rst_cmp_a",     32'(cmp_a),     0);
    check_eq("rst_cmp_b",     32'(cmp_b),     0);
    check_eq("rst_cfg_busy",  32'(cfg_busy),  0);
  endtask

  task automatic cfg_write(input int addr, input bit leaf, input int fidx, input int thr,
                           input int cls);
    cfg_we = 1'b1;
    cfg_addr = 5'(addr);
    cfg_data = {leaf, 4'(fidx), 3'(thr), 3'(cls)};
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr < NODES) begin
      m_leaf[addr] = leaf; m_fidx[addr] = fidx; m_thr[addr] = thr; m_cls[addr] = cls;
    end
  endtask

  task automatic rand_feat();
    for (int k = 0; k < NF; k++) feat[k] = $urandom_range(7, 0);
  endtask

  task automatic pack_feat();
    for (int k = 0; k < NF; k++) in_feat[k*FW +: FW] = 3'(feat[k]);
  endtask

  // One vector: accept, step through WALK checking operands, then DONE with backpressure.
  task automatic run_vector(input int hold, input bit poke);
    pack_feat();
    model_walk();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("accept_busy", 32'(cfg_busy), 1);
    for (int k = 0; k < exp_a.size(); k++) begin
      if (poke && k == 0) begin
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 11'h407;
      end
      check_eq("walk_out_valid", 32'(out_valid), 0);
      check_eq("walk_in_ready",  32'(in_ready),  0);
      check_eq("walk_cmp_a",     32'(cmp_a),     32'(exp_a[k]));
      check_eq("walk_cmp_b",     32'(cmp_b),     32'(exp_b[k]));
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    check_eq("done_out_valid", 32'(out_valid), 1);
    check_eq("done_out_class", 32'(out_class), 32'(exp_cls));
    check_eq("done_in_ready",  32'(in_ready),  0);
    check_eq("done_cmp_a",     32'(cmp_a),     0);
    check_eq("done_cmp_b",     32'(cmp_b),     0);
`ifdef TNN_WALK_PATHLEN_EN
    check_eq("done_path_len",  32'(path_len),  32'(exp_pl));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_out_valid", 32'(out_valid), 1);
      check_eq("hold_out_class", 32'(out_class), 32'(exp_cls));
      check_eq("hold_in_ready",  32'(in_ready),  0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("ret_out_valid", 32'(out_valid), 0);
    check_eq("ret_in_ready",  32'(in_ready),  1);
    check_eq("ret_cfg_busy",  32'(cfg_busy),  0);
  endtask

  initial begin
    in_feat = '0; cfg_addr = '0; cfg_data = '0;
    do_reset();

    // Unconfigured tree: root is a class-0 leaf with zero operands.
    rand_feat();
    run_vector(0, 1'b0);

    // One split on feature 2 against threshold 3.
    cfg_write(0, 1'b0, 2, 3, 0);
    cfg_write(1, 1'b1, 0, 0, 5);
    cfg_write(2, 1'b1, 0, 0, 6);
    rand_feat(); feat[2] = 5;
    run_vector(0, 1'b0);
    rand_feat(); feat[2] = 2;
    run_vector(1, 1'b0);

    // Full depth: thresh 7 everywhere forces the left spine down to node 15.
    do_reset();
    for (int i = 0; i < LB; i++) cfg_write(i, 1'b0, $urandom_range(10, 0), 7, 1);
    cfg_write(15, 1'b0, 3, 2, 4);
    rand_feat();
    run_vector(5, 1'b0);
    // Write attempted mid-walk must be dropped; the following vector sees the old tree.
    rand_feat();
    run_vector(0, 1'b1);
    rand_feat();
    run_vector(0, 1'b0);
    // Out-of-range address write is ignored.
    cfg_write(31, 1'b1, 0, 0, 7);

    // Reset in the middle of a walk.
    rand_feat(); pack_feat();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_eq("midrst_out_valid", 32'(out_valid), 0);
    check_eq("midrst_in_ready",  32'(in_ready),  1);
    check_eq("midrst_cfg_busy",  32'(cfg_busy),  0);
    for (int v = 0; v < 3; v++) begin
      rand_feat();
      run_vector(0, 1'b0);
    end

    // Out-of-range feature index reads as 0.
    cfg_write(0, 1'b0, 13, 2, 0);
    cfg_write(1, 1'b1, 0, 0, 3);
    cfg_write(2, 1'b1, 0, 0, 6);
    rand_feat();
    run_vector(0, 1'b0);

    // Random trees and vectors.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NODES; i++) begin
        cfg_write(i, ($urandom_range(3, 0) == 0), $urandom_range(15, 0), $urandom_range(7, 0),
                  $urandom_range(7, 0));
      end
      for (int v = 0; v < 12; v++) begin
        rand_feat();
        run_vector($urandom_range(2, 0), ($urandom_range(4, 0) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tnn_tree_walker.md
Name: tnn_tree_walker

Overview:
- Sequential decision-tree evaluator for the ternary/tree neural network (TNN) classifier datapath.
- Accepts one quantised feature vector and walks a stored binary tree, one node per cycle.
- At each node it drives an (feature, threshold) operand pair into the external approximate 3-bit comparator and consumes its 1-bit greater-than result to pick the child.
- Emits the leaf class through a valid/ready handshake.

Parameters:
- N_FEAT, 11, number of features per input vector.
- FEAT_W, 3, bits per feature and per threshold; matches the comparator operand width.
- DEPTH, 4, maximum tree depth; node count NODES = 2^(DEPTH+1)-1 (31).
- CLASS_W, 3, class label width.
- FIDX_W, clog2(N_FEAT) = 4, derived; feature index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  block can accept a vector
- in_feat  in  N_FEAT*FEAT_W  packed features; feature k is in_feat[k*FEAT_W +: FEAT_W]
- cmp_a  out  FEAT_W  comparator operand A: the selected feature
- cmp_b  out  FEAT_W  comparator operand B: the node threshold
- cmp_gt  in  1  comparator result; combinational, sampled in the same cycle
- out_valid  out  1  class result valid
- out_ready  in  1  consumer accepts the result
- out_class  out  CLASS_W  leaf class
- cfg_we  in  1  node-table write strobe
- cfg_addr  in  5  node index, 0..NODES-1
- cfg_data  in  1+FIDX_W+FEAT_W+CLASS_W  node word {is_leaf, feat_idx, thresh, class}
- cfg_busy  out  1  high when the block is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; out_class=0; cmp_a=0; cmp_b=0; cfg_busy=0.
- Reset also rewrites every table entry to is_leaf=1, class=0. A reset mid-walk aborts the walk and loses the configuration.
- Node table: NODES register entries with combinational read. Children of node i are 2i+1 (left) and 2i+2 (right).
- Nodes at depth DEPTH (indices 15..30) are always treated as leaves, whatever their is_leaf bit.
- Config writes: cfg_we takes effect only in IDLE. Writes when cfg_busy=1, or with cfg_addr >= NODES, are silently ignored.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: latch in_feat, set idx=0, go to WALK.
  - A cfg_we in the same cycle is also applied.
- FSM WALK:
  - cmp_a = latched feature[node.feat_idx]; cmp_a=0 if feat_idx >= N_FEAT.
  - cmp_b = node.thresh.
  - If the node is a leaf: capture node.class into out_class and go to DONE.
  - Otherwise: idx <= 2*idx+1+cmp_gt. cmp_gt=1 selects the right child.
- FSM DONE:
  - out_valid=1, with out_class held stable.
  - On out_valid&out_ready: go to IDLE.
  - in_ready=0 throughout, so no new vector overlaps a pending result.
- cmp_a and cmp_b are driven with node data only in WALK; they are 0 in IDLE and DONE.
- Latency: for a leaf at depth d, WALK occupies cycles T+1..T+d+1 and out_valid rises at T+d+2.
  - Minimum: 2 cycles.
  - Maximum: DEPTH+2 = 6 cycles.
- Throughput: one vector per (d+3) cycles with out_ready held high.
- cfg_busy = (state != IDLE).

Optional Feature:
- Macro: TNN_WALK_PATHLEN_EN.
- When defined:
  - Adds output port path_len, width clog2(DEPTH+1) = 3 bits.
  - path_len counts the non-leaf nodes evaluated, i.e. the comparator uses, for the current vector.
  - It is cleared on acceptance and valid together with out_valid.
  - Reset value 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Unconfigured tree: reset, then a vector accepted at T -> out_valid at T+2 with out_class=0; cmp_a/cmp_b stay 0; path_len=0.
- One split:
  - Configure node0={0,2,3,x}, node1={1,x,x,5}, node2={1,x,x,6}.
  - Feature2=5 with an exact-compare model -> cmp_a=5, cmp_b=3 at T+1; out_class=6 at T+3; path_len=1.
  - Feature2=2 -> out_class=5.
- Full depth:
  - All internal nodes thresh=7; node15 class=4.
  - Any vector -> cmp_gt always 0 -> idx sequence 0,1,3,7,15; out_class=4 at T+6; path_len=4.
  - The is_leaf bit of node15 is ignored.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid and out_class stable, in_ready=0. Raise out_ready -> IDLE the next cycle, in_ready=1.
- Out-of-range feature index: node0 feat_idx=13 -> cmp_a=0 in the WALK cycle.
- Config and reset during a walk:
  - cfg_we during WALK -> table unchanged; the next vector uses the old tree.
  - rst asserted during WALK -> next cycle out_valid=0, in_ready=1, and every node reads back as a class-0 leaf.
